// File: rtl/overlay_pkg.sv
// Shared types and helpers for the overlay fetch stage: RGBA4444 pixel layout
// and the number of pixels carried by each 32-bit SDRAM word.
package overlay_pkg;

    localparam int OVL_WORD_PIXELS = 2;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] g;
        logic [3:0] r;
    } rgba4444_t;

    function automatic rgba4444_t unpack_rgba(input logic [15:0] hw);
        rgba4444_t p;
        p.a = hw[15:12];
        p.b = hw[11:8];
        p.g = hw[7:4];
        p.r = hw[3:0];
        return p;
    endfunction

endpackage

// File: rtl/overlay_fifo.sv
// Small synchronous word FIFO with flush; head_o shows the oldest entry.
// Pushes while full and pops while empty are ignored.
module overlay_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   Reset_I,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       head_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      count_q;
    logic             do_push, do_pop;

    assign do_push = push_i && (count_q != (PW+1)'(DEPTH)) && !flush_i;
    assign do_pop  = pop_i && (count_q != '0) && !flush_i;

    // NOTE: sequential state is written with <= only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge Reset_I) begin
        if (!Reset_I) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the storage array has no reset; count_q alone says which entries
    // are valid, so resetting the data would only cost flops.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/overlay_fetch.sv
// Overlay fetch: prefetches 32-bit SDRAM words into a FIFO and emits one RGBA4444
// pixel per active ce_pix. Define OVERLAY_FETCH_STATS_EN for the underflow_cnt port.
module overlay_fetch
    import overlay_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 24
) (
    input  logic              clk,
    input  logic              Reset_I,
    input  logic              enable,
    input  logic              ce_pix,
    input  logic              hblank,
    input  logic              vblank,
    input  logic              vsync,
    output logic              sd_req,
    output logic [ADDR_W-1:0] sd_addr,
    input  logic              sd_ack,
    input  logic [31:0]       sd_data,
    output logic [3:0]        pix_r,
    output logic [3:0]        pix_g,
    output logic [3:0]        pix_b,
    output logic [3:0]        pix_a,
    output logic              underflow
`ifdef OVERLAY_FETCH_STATS_EN
    ,
    output logic [15:0]       underflow_cnt
`endif
);

    localparam int CW   = $clog2(FIFO_DEPTH) + 1;
    localparam int HS_W = $clog2(OVL_WORD_PIXELS);
    localparam logic [HS_W-1:0] LAST_HALF = HS_W'(OVL_WORD_PIXELS - 1);

    logic              vsync_q;
    logic              sd_req_q, sd_req_d;
    logic [ADDR_W-1:0] sd_addr_q, sd_addr_d;
    logic [ADDR_W-2:0] word_ptr_q, word_ptr_d;
    logic              outstanding_q, outstanding_d;
    logic              discard_q, discard_d;
    logic [HS_W-1:0]   half_q, half_d;
    rgba4444_t         pix_q, pix_d;
    logic              underflow_q, underflow_d;

    logic              restart, flush, ack_v, push, pop, consume, empty;
    logic [31:0]       head;
    logic [CW-1:0]     fifo_count;

    assign restart = vsync && !vsync_q;
    // A disabled block is held in permanent restart.
    assign flush   = restart || !enable;
    assign ack_v   = sd_ack && outstanding_q;
    assign push    = ack_v && !discard_q && !flush;
    assign empty   = (fifo_count == '0);
    assign consume = ce_pix && !hblank && !vblank && !flush;
    assign pop     = consume && !empty && (half_q == LAST_HALF);

    overlay_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .Reset_I (Reset_I),
        .flush_i (flush),
        .push_i  (push),
        .wdata_i (sd_data),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (fifo_count)
    );

    // NOTE: every _d gets its hold value first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        sd_req_d      = 1'b0;
        sd_addr_d     = sd_addr_q;
        word_ptr_d    = word_ptr_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        half_d        = half_q;
        pix_d         = pix_q;
        underflow_d   = underflow_q;

        if (!flush && !outstanding_q && (fifo_count < CW'(FIFO_DEPTH))) begin
            sd_req_d      = 1'b1;
            sd_addr_d     = {word_ptr_q, 1'b0};
            word_ptr_d    = word_ptr_q + 1'b1;
            outstanding_d = 1'b1;
        end

        // A response in the restart cycle is dropped by the flush itself, so
        // discard is only armed for a read that is still in flight afterwards.
        if (ack_v) begin
            outstanding_d = 1'b0;
            discard_d     = 1'b0;
        end else if (flush && outstanding_q) begin
            discard_d = 1'b1;
        end

        if (flush) begin
            word_ptr_d  = '0;
            half_d      = '0;
            underflow_d = 1'b0;
        end else if (consume) begin
            if (empty) begin
                pix_d       = '0;
                underflow_d = 1'b1;
            end else begin
                pix_d  = unpack_rgba((half_q == LAST_HALF) ? head[31:16] : head[15:0]);
                half_d = half_q + 1'b1;
            end
        end

        if (!enable) pix_d = '0;
    end

    always_ff @(posedge clk or negedge Reset_I) begin
        if (!Reset_I) begin
            vsync_q       <= 1'b0;
            sd_req_q      <= 1'b0;
            sd_addr_q     <= '0;
            word_ptr_q    <= '0;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            half_q        <= '0;
            pix_q         <= '0;
            underflow_q   <= 1'b0;
        end else begin
            vsync_q       <= vsync;
            sd_req_q      <= sd_req_d;
            sd_addr_q     <= sd_addr_d;
            word_ptr_q    <= word_ptr_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            half_q        <= half_d;
            pix_q         <= pix_d;
            underflow_q   <= underflow_d;
        end
    end

`ifdef OVERLAY_FETCH_STATS_EN
    logic [15:0] ucnt_q;

    always_ff @(posedge clk or negedge Reset_I) begin
        if (!Reset_I)
            ucnt_q <= '0;
        else if (consume && empty && (ucnt_q != 16'hFFFF))
            ucnt_q <= ucnt_q + 1'b1;
    end

    assign underflow_cnt = ucnt_q;
`endif

    assign sd_req    = sd_req_q;
    assign sd_addr   = sd_addr_q;
    assign pix_r     = pix_q.r;
    assign pix_g     = pix_q.g;
    assign pix_b     = pix_q.b;
    assign pix_a     = pix_q.a;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_overlay_fetch.sv
// Directed bench for overlay_fetch: an SDRAM responder acks 3 clk after each
// request and logs request addresses; pixel behaviour is checked from a vector table.
module tb_overlay_fetch;

    logic        clk = 1'b0;
    logic        Reset_I, enable, ce_pix, hblank, vblank, vsync;
    logic        sd_req, sd_ack;
    logic [23:0] sd_addr;
    logic [31:0] sd_data;
    logic [3:0]  pix_r, pix_g, pix_b, pix_a;
    logic        underflow;
`ifdef OVERLAY_FETCH_STATS_EN
    logic [15:0] underflow_cnt;
`endif

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [23:0] req_log [$];
    logic [31:0] data_q  [$];
    logic        ack_hold = 1'b0;

    always #5 clk = ~clk;

    overlay_fetch #(.FIFO_DEPTH(4), .ADDR_W(24)) dut (
        .clk       (clk),
        .Reset_I   (Reset_I),
        .enable    (enable),
        .ce_pix    (ce_pix),
        .hblank    (hblank),
        .vblank    (vblank),
        .vsync     (vsync),
        .sd_req    (sd_req),
        .sd_addr   (sd_addr),
        .sd_ack    (sd_ack),
        .sd_data   (sd_data),
        .pix_r     (pix_r),
        .pix_g     (pix_g),
        .pix_b     (pix_b),
        .pix_a     (pix_a),
        .underflow (underflow)
`ifdef OVERLAY_FETCH_STATS_EN
        ,
        .underflow_cnt (underflow_cnt)
`endif
    );

    typedef struct {
        logic        ce;
        logic        hb;
        logic        vb;
        logic [15:0] pix;   // expected {a,b,g,r}
        logic        uf;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [15:0] pix_now();
        return {pix_a, pix_b, pix_g, pix_r};
    endfunction

    // SDRAM model: one read in flight, data from data_q or a filler pattern.
    initial begin : responder
        int dly;
        bit busy;
        dly     = 0;
        busy    = 1'b0;
        sd_ack  = 1'b0;
        sd_data = '0;
        forever begin
            @(posedge clk);
            #1;
            sd_ack = 1'b0;
            if (!Reset_I) begin
                busy = 1'b0;
            end else begin
                if (busy) begin
                    if (dly > 1) begin
                        dly--;
                    end else if (!ack_hold) begin
                        sd_ack = 1'b1;
                        if (data_q.size() > 0) sd_data = data_q.pop_front();
                        else                   sd_data = 32'h7777_7777;
                        busy = 1'b0;
                    end
                end
                if (sd_req) begin
                    req_log.push_back(sd_addr);
                    busy = 1'b1;
                    dly  = 3;
                end
            end
        end
    end

    initial begin
        vecs = '{
            '{1'b1, 1'b0, 1'b0, 16'h1234, 1'b0},
            '{1'b1, 1'b1, 1'b0, 16'h1234, 1'b0},
            '{1'b1, 1'b0, 1'b0, 16'hF0A1, 1'b0},
            '{1'b1, 1'b0, 1'b1, 16'hF0A1, 1'b0},
            '{1'b0, 1'b0, 1'b0, 16'hF0A1, 1'b0},
            '{1'b1, 1'b0, 1'b0, 16'h9ABC, 1'b0},
            '{1'b1, 1'b0, 1'b0, 16'h5678, 1'b0},
            '{1'b1, 1'b0, 1'b0, 16'hCBA9, 1'b0},
            '{1'b1, 1'b0, 1'b0, 16'h0FED, 1'b0}
        };

        Reset_I = 1'b0;
        enable  = 1'b0;
        ce_pix  = 1'b0;
        hblank  = 1'b0;
        vblank  = 1'b0;
        vsync   = 1'b0;
        data_q  = '{32'hF0A1_1234, 32'h5678_9ABC, 32'h0FED_CBA9, 32'h1357_2468};
        tick(3);

        check("reset sd_req", 32'(sd_req), 32'd0);
        check("reset sd_addr", 32'(sd_addr), 32'd0);
        check("reset pix", 32'(pix_now()), 32'd0);
        check("reset underflow", 32'(underflow), 32'd0);

        // Prefetch fills the FIFO with four words and then stops.
        Reset_I = 1'b1;
        enable  = 1'b1;
        tick(40);
        check("prefetch count", req_log.size(), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("prefetch addr %0d", i), 32'(req_log[i]), 32'(2 * i));

        for (int i = 0; i < 9; i++) begin
            ce_pix = vecs[i].ce;
            hblank = vecs[i].hb;
            vblank = vecs[i].vb;
            tick(1);
            check($sformatf("vec%0d pix", i), 32'(pix_now()), 32'(vecs[i].pix));
            check($sformatf("vec%0d underflow", i), 32'(underflow), 32'(vecs[i].uf));
        end
        ce_pix = 1'b0;
        hblank = 1'b0;
        vblank = 1'b0;
        tick(1);
        check("refill req logged", 32'(req_log.size() > 4), 32'd1);
        check("refill addr", 32'(req_log[4]), 32'd8);

        // Starve the FIFO, then restart the frame with a read in flight.
        ack_hold = 1'b1;
        ce_pix   = 1'b1;
        tick(12);
        ce_pix = 1'b0;
        tick(1);
        check("underflow pix", 32'(pix_now()), 32'd0);
        check("underflow flag", 32'(underflow), 32'd1);
        vblank = 1'b1;
        tick(2);
        check("underflow sticky", 32'(underflow), 32'd1);
        vblank = 1'b0;

        data_q.delete();
        data_q.push_back(32'hDEAD_BEEF);
        data_q.push_back(32'h4321_8765);
        req_log.delete();
        vsync = 1'b1;
        tick(1);
        check("vsync clears underflow", 32'(underflow), 32'd0);
        ack_hold = 1'b0;
        tick(3);
        vsync = 1'b0;
        tick(20);
        check("restart req logged", 32'(req_log.size() > 0), 32'd1);
        check("restart first addr", 32'(req_log[0]), 32'd0);
        ce_pix = 1'b1;
        tick(1);
        check("fresh word lo", 32'(pix_now()), 32'h8765);
        tick(1);
        check("fresh word hi", 32'(pix_now()), 32'h4321);
        ce_pix = 1'b0;
        tick(20);

        // Disable mid-line.
        req_log.delete();
        enable = 1'b0;
        ce_pix = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check($sformatf("disabled sd_req %0d", i), 32'(sd_req), 32'd0);
            check($sformatf("disabled pix %0d", i), 32'(pix_now()), 32'd0);
        end
        check("disabled no reqs", req_log.size(), 32'd0);
        enable = 1'b1;
        ce_pix = 1'b0;
        tick(12);
        check("reenable req logged", 32'(req_log.size() > 0), 32'd1);
        check("reenable first addr", 32'(req_log[0]), 32'd0);

        // Fresh reset, held SDRAM: five empty consumes then a frame restart.
        Reset_I  = 1'b0;
        ack_hold = 1'b1;
        data_q.delete();
        tick(2);
        Reset_I = 1'b1;
        tick(2);
        ce_pix = 1'b1;
        tick(5);
        ce_pix = 1'b0;
        tick(1);
        check("empty consume pix", 32'(pix_now()), 32'd0);
        check("empty consume flag", 32'(underflow), 32'd1);
`ifdef OVERLAY_FETCH_STATS_EN
        check("underflow_cnt", 32'(underflow_cnt), 32'd5);
`endif
        vsync = 1'b1;
        tick(1);
        check("flag after vsync", 32'(underflow), 32'd0);
`ifdef OVERLAY_FETCH_STATS_EN
        check("underflow_cnt after vsync", 32'(underflow_cnt), 32'd5);
`endif
        vsync    = 1'b0;
        ack_hold = 1'b0;
        tick(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/overlay_fetch.md
Name: overlay_fetch

Overview:
- Pixel-rate overlay fetch stage for the SDRAM artwork overlay.
- Issues 32-bit reads on SDRAM channel 1 and prefetches them into a small FIFO.
- Splits each word into two RGBA4444 pixels and presents one pixel per active ce_pix to the alpha-blend/compositing stage.
- Replaces the inline fetch logic: adds flow control, frame restart and underflow reporting.

Parameters:
- FIFO_DEPTH, 4, number of 32-bit words buffered; power of two, minimum 2.
- ADDR_W, 24, width of the SDRAM halfword address.

Ports:
- clk  in  1  pixel-domain memory clock (48 MHz).
- Reset_I  in  1  asynchronous, active-low reset.
- enable  in  1  overlay loaded and in use; low flushes and idles the block.
- ce_pix  in  1  pixel clock enable.
- hblank  in  1  horizontal blank.
- vblank  in  1  vertical blank.
- vsync  in  1  vertical sync, active high.
- sd_req  out  1  one-cycle read request pulse.
- sd_addr  out  ADDR_W  halfword address; bit0 is always 0.
- sd_ack  in  1  one-cycle pulse; sd_data is valid in this cycle.
- sd_data  in  32  read data; [15:0] is the earlier pixel.
- pix_r, pix_g, pix_b, pix_a  out  4 each  current overlay pixel.
- underflow  out  1  sticky per frame: a pixel was needed while the FIFO was empty.

Behaviour:
- Reset values: sd_req=0, sd_addr=0, pix_*=0, underflow=0; FIFO empty; word pointer=0; half-select=0; outstanding=0; discard=0.
- Request rule: at most one read outstanding. Issue sd_req when all of these hold:
  - enable=1
  - outstanding=0
  - fifo_count < FIFO_DEPTH
- On a request: sd_addr={word_ptr,1'b0}; word_ptr increments; outstanding=1.
- Response rule: sd_ack with outstanding=1 clears outstanding. If discard=1, the data is dropped and discard clears. Otherwise the data is pushed into the FIFO.
- sd_ack with outstanding=0 is ignored.
- No overflow: a request is issued only when a FIFO slot is free, so a push can never hit a full FIFO.
- Pixel consume: condition is ce_pix & ~hblank & ~vblank & enable.
  - FIFO non-empty, half-select=0: output head[15:0].
  - FIFO non-empty, half-select=1: output head[31:16], then pop.
  - Half-select toggles on every non-empty consume.
  - FIFO empty: pixel outputs 0, underflow=1, half-select unchanged.
- Unpack: {a,b,g,r} = halfword[15:12],[11:8],[7:4],[3:0].
- Output timing: pixel outputs are registered and update 1 clk after the consuming ce_pix. They hold their value during blanking.
- A push and a pop in the same cycle is legal; count is unchanged.
- Frame restart: a vsync rising edge is detected on clk (registered previous value). In that cycle:
  - FIFO is flushed, word_ptr=0, half-select=0, underflow=0.
  - If outstanding=1, set discard=1.
  - The restart has priority over any concurrent request, push or pop.
- After restart, prefetch begins the next cycle, or once the in-flight read is discarded.
- enable low: behaves like a continuous restart. pix_*=0, sd_req=0. discard is still honoured for an in-flight read.
- Address wrap: word_ptr wraps modulo 2^(ADDR_W-1) with no error.

Optional Feature:
- Macro: OVERLAY_FETCH_STATS_EN.
- Defined: adds output underflow_cnt[15:0]. It counts empty-FIFO consumes across frames, saturates at 16'hFFFF, and is cleared only by reset.
- Not defined: port and counter are absent; underflow flag behaviour is unchanged.

Decomposition:
- Package overlay_pkg holds:
  - typedef rgba4444_t, a packed struct {a,b,g,r} of 4 bits each;
  - function unpack_rgba;
  - constant OVL_WORD_PIXELS=2.
- One sub-module: overlay_fifo, a synchronous FIFO with flush, push, pop, count and head output. Same clk/Reset_I.

Test Plan:
- Reset, enable=1, sd_ack returned 3 clk after each sd_req, idle video -> sd_req pulses at addresses 0,2,4,6 and then stops (FIFO full with 4 words); no further requests.
- FIFO preloaded with 32'hF0A1_1234, one active ce_pix -> pix={a=1,b=2,g=3,r=4}. Next active ce_pix -> {a=F,b=0,g=A,r=1}, then pop; new sd_req at address 8.
- Active pixels with sd_ack withheld until the FIFO drains -> pix=0 and underflow=1. After a vsync rising edge, underflow=0.
- vsync rising edge while a read is outstanding, sd_ack arrives with 32'hDEAD_BEEF -> data dropped; next request at address 0; first pixel comes from the fresh word.
- enable dropped mid-line -> sd_req stays 0 and pix=0. After re-enable, the first request is at address 0.
- With OVERLAY_FETCH_STATS_EN: 5 empty consumes, then vsync -> underflow_cnt=5 and is not cleared by vsync.
